// File: rtl/piso_register.sv
// piso_register: parallel-in serial-out shift register with ready/valid on both sides
module piso_register #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             recirc,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             last,
  output logic [WIDTH-1:0] par_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic mode;
  logic xfer, accept;
  assign sout_valid = state == SHIFT;
  assign last       = sout_valid & (cnt == CW'(1));
  assign load_ready = (state == IDLE) | (last & sout_ready);
  assign sout       = sreg[WIDTH-1];
  assign par_out    = sreg;
  assign xfer       = sout_valid & sout_ready;
  assign accept     = load_valid & load_ready;
  // a load on the final transfer overrides the shift so words stream without a gap
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= data_in;
      cnt   <= CW'(WIDTH);
      mode  <= recirc;
    end else if (xfer) begin
      sreg  <= {sreg[WIDTH-2:0], mode ? sreg[WIDTH-1] : 1'b0};
      cnt   <= cnt - CW'(1);
      state <= last ? IDLE : SHIFT;
    end
  end
endmodule

// File: tb/tb_piso_register.sv
// tb_piso_register: directed and randomized checks of piso_register against a word-level model
module tb_piso_register;
  localparam int W = 5;
  logic clk = 0, clear = 0, load_valid = 0, recirc = 0, sout_ready = 0;
  logic [W-1:0] data_in = '0;
  logic load_ready, sout, sout_valid, last;
  logic [W-1:0] par_out;
  int errs = 0, checks = 0;
  logic armed = 0;
  logic busy = 0, mmode = 0;
  logic [W-1:0] mword = '0, midle = '0;
  int k = 0;
  logic s_sout, s_valid, s_last, s_lr;
  logic [W-1:0] s_par;
  logic [9:0] bits, lasts;
  logic [W-1:0] rexp [6];

  piso_register #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .recirc(recirc), .sout(sout), .sout_valid(sout_valid),
    .sout_ready(sout_ready), .last(last), .par_out(par_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) v = {v[W-2:0], v[W-1]};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic lv, input logic [W-1:0] d, input logic rc, input logic sr, input logic clr);
    logic [W-1:0] e_par;
    logic e_last, e_lr;
    @(negedge clk);
    load_valid = lv; data_in = d; recirc = rc; sout_ready = sr; clear = clr;
    #1;
    e_par  = busy ? (mmode ? rotl(mword, k) : W'(mword << k)) : midle;
    e_last = busy && k == W - 1;
    e_lr   = !busy || (e_last && sr);
    if (armed) begin
      chk("sout_valid", sout_valid, busy);
      chk("sout", sout, e_par[W-1]);
      chk("last", last, e_last);
      chk("par_out", par_out, e_par);
      chk("load_ready", load_ready, e_lr);
    end
    s_sout = sout; s_valid = sout_valid; s_last = last; s_lr = load_ready; s_par = par_out;
    if (clr) begin
      busy = 0; midle = '0; k = 0; mmode = 0; armed = 1;
    end else if (lv && e_lr) begin
      busy = 1; mword = d; mmode = rc; k = 0;
    end else if (busy && sr) begin
      k++;
      if (k == W) begin
        busy = 0;
        midle = mmode ? mword : '0;
      end
    end
  endtask

  initial begin
    rexp = '{5'b10011, 5'b00111, 5'b01110, 5'b11100, 5'b11001, 5'b10011};
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_par", s_par, 0);
    chk("rst_ready", s_lr, 1);
    chk("rst_last", s_last, 0);
    // plain shift
    step(1, 5'b10110, 0, 1, 0);
    for (int i = 0; i < W; i++) begin
      step(0, '0, 0, 1, 0);
      bits = {bits[8:0], s_sout};
      lasts = {lasts[8:0], s_last};
    end
    chk("plain_bits", bits[4:0], 5'b10110);
    chk("plain_last", lasts[4:0], 5'b00001);
    step(0, '0, 0, 1, 0);
    chk("plain_end_valid", s_valid, 0);
    chk("plain_end_par", s_par, 0);
    chk("plain_end_ready", s_lr, 1);
    // recirculate
    step(1, 5'b10011, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 0, 1, 0);
      chk("recirc_par", s_par, rexp[i]);
      if (i < W) bits = {bits[8:0], s_sout};
    end
    chk("recirc_bits", bits[4:0], 5'b10011);
    chk("recirc_idle", s_valid, 0);
    // back-to-back
    step(1, 5'b11000, 0, 1, 0);
    for (int i = 0; i < 2 * W; i++) begin
      step(i < W, 5'b00101, 0, 1, 0);
      if (i == W - 1) chk("b2b_ready_on_last", s_lr, 1);
      bits = {bits[8:0], s_sout};
      lasts = {lasts[8:0], s_last};
    end
    chk("b2b_bits", bits, 10'b1100000101);
    chk("b2b_last", lasts, 10'b0000100001);
    // backpressure
    step(1, 5'b10110, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 0, !(i >= 2 && i < 5), 0);
      bits = {bits[8:0], s_sout};
      if (i >= 2 && i < 5) begin
        chk("bp_par", s_par, 5'b11000);
        chk("bp_last", s_last, 0);
        chk("bp_ready", s_lr, 0);
      end
    end
    chk("bp_bits", bits[7:0], 8'b10111110);
    // reset mid-word, with a load offered during clear
    step(1, 5'b11111, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(1, 5'b10101, 1, 1, 1);
    step(0, '0, 0, 1, 0);
    chk("clr_valid", s_valid, 0);
    chk("clr_par", s_par, 0);
    chk("clr_ready", s_lr, 1);
    step(1, 5'b01010, 0, 1, 0);
    for (int i = 0; i < W; i++) begin
      step(0, '0, 0, 1, 0);
      bits = {bits[8:0], s_sout};
    end
    chk("clr_fresh_bits", bits[4:0], 5'b01010);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) != 0, W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
